// File: rtl/readout_pkg.sv
// Shared types and helpers for the readout scheduler and its arbiter pieces.
package readout_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic            valid,
  output logic [2:0]      idx
);

  logic [NREQ-1:0] rot;
  logic [3:0]      sum;

  always_comb begin
    rot   = NREQ'({req, req} >> ptr);
    valid = |rot;
    sum   = '0;
    // Walk downward so the lowest rotated position wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) sum = 4'(k) + {1'b0, ptr};
    end
    if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
    idx = sum[2:0];
  end

endmodule

// File: rtl/readout_sched.sv
// Round-robin burst address sequencer shared by NREQ requesters.
// Optional abort port pair enabled by defining READOUT_ABORT_EN.
//
//   state   | meaning
//   IDLE    | arbitrate; sample req/base/len, launch burst next cycle
//   RUN     | one address per cycle until count reaches zero (or abort)
//   GAP     | GAP forced idle cycles before next arbitration
module readout_sched
  import readout_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int GAP  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] base,
  input  logic [NREQ*AW-1:0] len,
  output logic [NREQ-1:0]   grant,
  output logic [AW-1:0]     addr,
  output logic              addr_valid,
  output logic              last,
  output logic              busy,
`ifdef READOUT_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic [2:0]        owner
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [2:0]      owner_q, owner_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            aborted_q, aborted_d;

  logic            pick_valid;
  logic [2:0]      pick_idx;
  logic [7:0]      pick_oh;
  logic [AW-1:0]   sel_base, sel_len;
  logic            end_burst;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_base = '0;
    sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == 3'(i)) begin
        sel_base = base[i*AW +: AW];
        sel_len  = len[i*AW +: AW];
      end
    end
    pick_oh = 8'(1) << pick_idx;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    last_d    = last_q;
    gap_d     = gap_q;
    aborted_d = 1'b0;
    end_burst = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_oh[NREQ-1:0];
          owner_d = onehot_to_idx(pick_oh);
          addr_d  = sel_base;
          cnt_d   = sel_len;
          valid_d = 1'b1;
          last_d  = (sel_len == '0);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          end_burst = 1'b1;
`ifdef READOUT_ABORT_EN
        end else if (abort) begin
          end_burst = 1'b1;
          aborted_d = 1'b1;
`endif
        end else begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
          last_d = (cnt_q == AW'(1));
        end
        if (end_burst) begin
          grant_d = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          ptr_d   = (owner_q == 3'(NREQ - 1)) ? 3'd0 : owner_q + 3'd1;
          gap_d   = GW'(GAP - 1);
          state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      gap_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      aborted_q <= aborted_d;
    end
  end

  assign grant      = grant_q;
  assign owner      = owner_q;
  assign addr       = addr_q;
  assign addr_valid = valid_q;
  assign last       = last_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef READOUT_ABORT_EN
  assign aborted = aborted_q;
`else
  logic unused_aborted;
  assign unused_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_readout_sched.sv
// Self-checking bench for readout_sched: directed table, corner sequences, random traffic vs. a timeline model.
module tb_readout_sched;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int GAP  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0]    req  = '0;
  logic [NREQ*AW-1:0] base = '0;
  logic [NREQ*AW-1:0] len  = '0;
  logic [NREQ-1:0]    grant;
  logic [AW-1:0]      addr;
  logic               addr_valid, last, busy;
  logic [2:0]         owner;
  logic               abort = 1'b0;
  logic               aborted;

  always #5 clk = ~clk;

  readout_sched #(.NREQ(NREQ), .AW(AW), .GAP(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .base       (base),
    .len        (len),
    .grant      (grant),
    .addr       (addr),
    .addr_valid (addr_valid),
    .last       (last),
    .busy       (busy),
`ifdef READOUT_ABORT_EN
    .abort      (abort),
    .aborted    (aborted),
`endif
    .owner      (owner)
  );

`ifndef READOUT_ABORT_EN
  assign aborted = 1'b0;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Timeline model: each burst occupies cycles [m_start, m_end], the block is busy until m_free.
  int cyc, m_free, m_start, m_end, m_ptr, m_owner, m_base;
  bit m_have, m_aborted;

  task automatic model_reset();
    m_free = cyc; m_start = 1; m_end = 0;
    m_ptr = 0; m_owner = 0; m_base = 0; m_have = 0; m_aborted = 0;
  endtask

  task automatic model_step();
    int prev, w, l;
    prev = cyc;
    cyc++;
    m_aborted = 0;
    if (prev >= m_free) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      if (w >= 0) begin
        l       = int'((len >> (w * AW)) & 32'hFF);
        m_base  = int'((base >> (w * AW)) & 32'hFF);
        m_owner = w;
        m_start = cyc;
        m_end   = cyc + l;
        m_free  = m_end + 1 + GAP;
        m_ptr   = (w + 1) % NREQ;
        m_have  = 1;
      end
    end
`ifdef READOUT_ABORT_EN
    else if (abort && prev >= m_start && prev < m_end) begin
      m_end     = prev;
      m_free    = prev + 1 + GAP;
      m_aborted = 1;
    end
`endif
  endtask

  task automatic tick();
    bit inb;
    int e_addr;
    @(posedge clk); #1;
    model_step();
    inb = (cyc >= m_start) && (cyc <= m_end);
    if (inb)         e_addr = (m_base + cyc - m_start) & 8'hFF;
    else if (m_have) e_addr = (m_base + m_end - m_start) & 8'hFF;
    else             e_addr = 0;
    chk("grant", int'(grant), inb ? (1 << m_owner) : 0);
    chk("addr", int'(addr), e_addr);
    chk("addr_valid", int'(addr_valid), int'(inb));
    chk("last", int'(last), int'(inb && cyc == m_end));
    chk("busy", int'(busy), int'(cyc < m_free));
    chk("owner", int'(owner), m_owner);
`ifdef READOUT_ABORT_EN
    chk("aborted", int'(aborted), int'(m_aborted));
`endif
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin tick(); n++; end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; abort = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_grant", int'(grant), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] base;
    logic [NREQ*AW-1:0] len;
    int owner, first, lasta, n;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int own0, first, lasta, nv, nlast, n, gcnt, prev_g;
    int gown[5];
    int gcyc[5];
    bit saw_last;

    tbl[0] = '{4'b0001, 32'h0000_00F0, 32'h0000_0003, 0, 'hF0, 'hF3, 4};
    tbl[1] = '{4'b0010, 32'h0000_FE00, 32'h0000_0300, 1, 'hFE, 'h01, 4};
    tbl[2] = '{4'b1001, 32'h1000_0000, 32'h0000_0000, 3, 'h10, 'h10, 1};
    tbl[3] = '{4'b0110, 32'h0000_4000, 32'h0000_0100, 1, 'h40, 'h41, 2};
    tbl[4] = '{4'b0011, 32'h0000_0080, 32'h0000_0002, 0, 'h80, 'h82, 3};
    tbl[5] = '{4'b0100, 32'h0000_0000, 32'h00FF_0000, 2, 'h00, 'hFF, 256};

    cyc = 0;
    do_reset();
    tick();

    for (int v = 0; v < 6; v++) begin
      base = tbl[v].base; len = tbl[v].len; req = tbl[v].req;
      tick();
      req = '0;
      own0 = int'(owner); first = int'(addr);
      nv = 0; nlast = 0; lasta = -1;
      while (addr_valid && nv < 300) begin
        nv++;
        if (last) begin nlast++; lasta = int'(addr); end
        tick();
      end
      chk($sformatf("v%0d_owner", v), own0, tbl[v].owner);
      chk($sformatf("v%0d_first", v), first, tbl[v].first);
      chk($sformatf("v%0d_last", v), lasta, tbl[v].lasta);
      chk($sformatf("v%0d_nvalid", v), nv, tbl[v].n);
      chk($sformatf("v%0d_nlast", v), nlast, 1);
      wait_idle();
    end

    // All four requesting with single-address bursts: strict rotation.
    do_reset();
    base = 32'h3020_1000; len = '0; req = 4'hF;
    gcnt = 0; n = 0; prev_g = 0;
    while (gcnt < 5 && n < 60) begin
      tick(); n++;
      if (grant != 0 && prev_g == 0) begin gown[gcnt] = int'(owner); gcyc[gcnt] = cyc; gcnt++; end
      prev_g = int'(grant);
    end
    chk("rr_count", gcnt, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("rr_owner%0d", i), gown[i], i % NREQ);
    for (int i = 1; i < 5; i++) chk($sformatf("rr_spacing%0d", i), gcyc[i] - gcyc[i-1], GAP + 2);
    req = '0;
    wait_idle();

    // Reset during the third address; the held request restarts from base.
    do_reset();
    base = 32'h0000_0020; len = 32'h0000_0005; req = 4'b0001;
    tick(); tick(); tick();
    chk("mid_addr3", int'(addr), 'h22);
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", int'(grant), 0);
    chk("async_addr", int'(addr), 0);
    chk("async_valid", int'(addr_valid), 0);
    chk("async_last", int'(last), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_owner", int'(owner), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    tick();
    chk("restart_addr", int'(addr), 'h20);
    chk("restart_grant", int'(grant), 1);
    req = '0;
    wait_idle();

`ifdef READOUT_ABORT_EN
    // Pointer is 1 here; requester 1 wins, is aborted on its 2nd address, then requester 0 follows after GAP.
    base = 32'h0000_3050; len = 32'h0000_0500; req = 4'b0011;
    tick();
    chk("ab_owner", int'(owner), 1);
    req = 4'b0001;
    tick();
    chk("ab_addr2", int'(addr), 'h31);
    abort = 1'b1;
    saw_last = 1'b0;
    tick();
    abort = 1'b0;
    chk("ab_valid", int'(addr_valid), 0);
    chk("ab_pulse", int'(aborted), 1);
    chk("ab_grant", int'(grant), 0);
    n = 0;
    while (grant == 0 && n < 20) begin
      tick(); n++;
      if (aborted) chk("ab_single_pulse", 1, 0);
      if (last) saw_last = 1'b1;
    end
    chk("ab_regrant_delay", n, GAP + 1);
    chk("ab_next_owner", int'(owner), 0);
    chk("ab_no_last", int'(saw_last), 0);
    req = '0;
    wait_idle();
`endif

    // Random traffic against the timeline model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) req = req ^ NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        base[i*AW +: AW] = AW'($urandom);
        len[i*AW +: AW]  = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(0, 40)) : AW'($urandom_range(0, 5));
      end
`ifdef READOUT_ABORT_EN
      abort = ($urandom_range(0, 11) == 0);
`endif
      tick();
    end
    req = '0; abort = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/readout_sched.md
Name: readout_sched

Overview:
Round-robin scheduler that shares one readout address sequencer between NREQ requesters.
Each requester asks for a burst of consecutive addresses (base, length). The block grants one requester at a time, drives the shared address bus with a valid strobe for the burst, and signals completion.
Sits between the front-end trigger/readout controllers and the shared readout memory/DAQ path.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 8, address width; addresses wrap modulo 2^AW
GAP, 2, forced idle cycles between bursts (0 = back-to-back through ARB only)

Ports:
clk  in  1  single system clock, all logic on posedge
rst_n  in  1  reset, asynchronous, active-low
req  in  NREQ  per-requester request level; held until grant
base  in  NREQ*AW  per-requester start address, slice i = base[i*AW +: AW]
len  in  NREQ*AW  per-requester burst length minus 1 (0 -> 1 addr, 2^AW-1 -> 2^AW addrs)
grant  out  NREQ  one-hot owner, held for whole burst
addr  out  AW  current address
addr_valid  out  1  addr is valid this cycle
last  out  1  high with final address of burst
busy  out  1  high in any state except IDLE
owner  out  3  binary index of current or most recent owner

Behaviour:
- Reset (async on rst_n low): state = IDLE; grant = 0, addr = 0, addr_valid = 0, last = 0, busy = 0, owner = 0. Round-robin pointer = 0. Applies mid-burst with no completion pulse.
- States: IDLE, RUN, GAP.
- IDLE:
  - Winner = first i with req[i]=1, searching from pointer upward and wrapping.
  - If any req: register grant[winner] and owner. Latch addr = base[winner] and remaining count = len[winner]. Set addr_valid = 1. Go to RUN.
  - Latency: req high in cycle n -> grant and first valid addr in cycle n+1.
- RUN: one address per cycle.
  - Each cycle: addr <= addr+1 (mod 2^AW), count <= count-1.
  - last = 1 when count == 0, i.e. with the final address.
  - Cycle after last: addr_valid = 0, grant = 0, pointer = owner+1 (mod NREQ). Go to GAP if GAP>0, else IDLE.
  - Burst is exactly len+1 valid cycles.
- GAP: hold GAP cycles with addr_valid = 0 and busy = 1, then go to IDLE. Requests are ignored, not lost, while their req stays high.
- req/base/len are sampled only in IDLE. Changes or req drops during RUN have no effect. A requester dropping req before grant withdraws its request.
- Owner still holding req at burst end competes again but has lowest priority (pointer passed it).
- Simultaneous requests: pointer order decides; no requester starves (worst-case wait = (NREQ-1) bursts).
- addr holds its last value when not valid.

Optional Feature:
READOUT_ABORT_EN:
- Adds input abort (1 bit) and output aborted (1 bit).
- With the macro defined, abort high in RUN makes the next cycle behave as the cycle after last: valid drops, grant drops, pointer advances, aborted pulses for 1 cycle, last is not asserted. abort outside RUN is ignored.
- Without the macro, the ports are absent and bursts always run to completion.

Decomposition:
- Package readout_pkg: state enum (IDLE, RUN, GAP), default AW/NREQ constants, function for one-hot -> index.
- Sub-module rr_pick: combinational round-robin picker (req, pointer -> valid, winner index). Reusable by other arbiters.

Test Plan:
1. req=0001, base0=8'hF0, len0=3 -> grant 0001 from cycle n+1; addr F0,F1,F2,F3 valid 4 cycles; last with F3; busy low 1+GAP cycles later.
2. req=1111 held, all len=0 -> grants in order 0,1,2,3,0; each burst 1 valid cycle; GAP=2 idle cycles between bursts.
3. base1=8'hFE, len1=3 -> addr FE,FF,00,01; last with 01 (wrap).
4. len2=8'hFF -> 256 valid cycles, last on 256th, count does not underflow into an extra cycle.
5. rst_n low during 3rd address of a burst -> all outputs 0 immediately; after release, the same req restarts the burst from base.
6. READOUT_ABORT_EN build: abort during 2nd address of len=5 burst -> valid drops next cycle, aborted pulses once, last never asserted, next requester granted after GAP.
